// File: rtl/io_debounce.sv
// Pin conditioner: synchronizer chain plus stability-count debounce with a registered level output.
// Optional rise/fall strobes are built only when IO_DEBOUNCE_EDGE_EN is defined; otherwise both are tied to 0.
module io_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_s;
    logic                   out_r;
    logic                   out_s;
    logic                   s_s;

    assign s_s = sync_r[SYNC_STAGES-1];

    // Synchronizer chain, stability counter and debounced level register
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            out_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], in};
            cnt_r  <= cnt_s;
            out_r  <= out_s;
        end
    end

    // Filter next state: any agreeing cycle drops all accumulated credit
    always_comb begin
        cnt_s = {CNT_W{1'b0}};
        out_s = out_r;
        if (s_s == out_r) begin
            cnt_s = {CNT_W{1'b0}};
            out_s = out_r;
        end else if (cnt_r >= CNT_LAST) begin
            // >= rather than == so a corrupted counter cannot run past the limit
            cnt_s = {CNT_W{1'b0}};
            out_s = s_s;
        end else begin
            cnt_s = cnt_r + CNT_ONE;
            out_s = out_r;
        end
    end

    assign out = out_r;

`ifdef IO_DEBOUNCE_EDGE_EN
    logic rise_r;
    logic fall_r;

    // Edge strobes, aligned with the cycle the new level first appears on out
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            rise_r <= out_s & ~out_r;
            fall_r <= ~out_s & out_r;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule
